// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Holds the arbiter state enum, default sizes and an index-width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// Combinational round-robin picker: first requester after last_i, with wrap.
// Ports: req_i (request vector), last_i (last owner) -> idx_o, valid_o.
module rr_arb_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  // Walk offsets from far to near so the nearest requester wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(last_i) + i) % N);
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among producers.
// Ports: clk_i, rst_ni, req_i, data_i, gnt_o, fifo_full_i, fifo_wr_en_o,
// fifo_wr_data_o, owner_o, busy_o, wr_count_o.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*WIDTH-1:0]      data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [WIDTH-1:0]              fifo_wr_data_o,
  output logic [idx_width(NUM_REQ)-1:0] owner_o,
  output logic                          busy_o,
  output logic [CNT_WIDTH-1:0]          wr_count_o
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BURST - 1);

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  last_owner_q, last_owner_d;
  logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;

  logic          in_burst;
  logic          xfer;
  logic          burst_end;
  logic [IW-1:0] pick_last;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;

  assign in_burst  = (state_q == BURST);
  assign xfer      = in_burst && req_i[owner_q] && !fifo_full_i;
  assign burst_end = in_burst &&
                     (!req_i[owner_q] ||
                      (xfer && burst_cnt_q == LAST_CNT));
  // On a burst end the picker already sees the finishing owner as last.
  assign pick_last = burst_end ? owner_q : last_owner_q;

  rr_arb_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (req_i),
    .last_i  (pick_last),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d     = BURST;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + BW'(1);
          wr_cnt_d    = wr_cnt_q + CNT_WIDTH'(1);
        end
        if (burst_end) begin
          last_owner_d = owner_q;
          burst_cnt_d  = '0;
          if (pick_vld) begin
            owner_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      wr_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  always_comb begin
    fifo_wr_data_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == IW'(k)) begin
        fifo_wr_data_o = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign gnt_o = (in_burst && !fifo_full_i) ?
                 (NUM_REQ'(1) << owner_q) : '0;
  assign fifo_wr_en_o = xfer;
  assign owner_o      = owner_q;
  assign busy_o       = in_burst;
  assign wr_count_o   = wr_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           full;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic [1:0]     owner;
  logic           busy;
  logic [CW-1:0]  wr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .MAX_BURST (MB),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .data_i         (data),
    .gnt_o          (gnt),
    .fifo_full_i    (full),
    .fifo_wr_en_o   (wr_en),
    .fifo_wr_data_o (wr_data),
    .owner_o        (owner),
    .busy_o         (busy),
    .wr_count_o     (wr_count)
  );

  typedef struct {
    bit busy;
    int owner;
    int last;
    int cnt;
    int wr;
  } mstate_t;

  mstate_t m;

  function automatic int pick(logic [N-1:0] r, int last);
    for (int i = 1; i <= N; i++) begin
      if (r[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  // One clock of the arbiter seen as bursts of granted words.
  function automatic mstate_t step(mstate_t s, logic [N-1:0] r, logic f);
    mstate_t n = s;
    int p;
    if (!s.busy) begin
      p = pick(r, s.last);
      if (p >= 0) begin
        n.busy = 1'b1;
        n.owner = p;
        n.cnt = 0;
      end
    end else begin
      if (r[s.owner] && !f) begin
        n.cnt = s.cnt + 1;
        n.wr = (s.wr + 1) % (1 << CW);
      end
      if (!r[s.owner] || n.cnt == MB) begin
        n.last = s.owner;
        n.cnt = 0;
        p = pick(r, n.last);
        if (p >= 0) n.owner = p;
        else n.busy = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{busy: 1'b0, owner: 0, last: N - 1, cnt: 0, wr: 0};
    else m <= step(m, req, full);
  end

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      assert (!(wr_en && full)) else begin
        errors++;
        $display("FAIL wr_en_while_full got wr_en=%b full=%b", wr_en, full);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    full = 1'b0;
    data = '0;
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0 || wr_en !== 1'b0 || busy !== 1'b0 ||
        wr_count !== 4'd0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_init got gnt=%b wr=%b busy=%b cnt=%0d own=%0d exp 0",
               gnt, wr_en, busy, wr_count, owner);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    #1;
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_prebusy got wr_en=%b exp 1", wr_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0 || wr_en !== 1'b0 || busy !== 1'b0 ||
        wr_count !== 4'd0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid got gnt=%b wr=%b busy=%b cnt=%0d own=%0d exp 0",
               gnt, wr_en, busy, wr_count, owner);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = '0;
    @(negedge clk);
    req = 4'b0001;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_latency0 got gnt=%b exp 0000", gnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_latency1 got gnt=%b busy=%b exp 0001 1", gnt, busy);
    end
    req = '0;
  endtask

  task automatic test_single_stream();
    int n = 0;
    do_reset();
    for (int cyc = 0; cyc < 20 && n < 8; cyc++) begin
      @(negedge clk);
      req = 4'b0100;
      data = $urandom;
      data[2*W +: W] = 8'(8'hA0 + n);
      #1;
      checks++;
      if (wr_en !== 1'(cyc >= 1)) begin
        errors++;
        $display("FAIL single_gap cyc=%0d got wr_en=%b exp %b", cyc, wr_en, cyc >= 1);
      end
      if (wr_en === 1'b1) begin
        checks++;
        if (wr_data !== 8'(8'hA0 + n)) begin
          errors++;
          $display("FAIL single_data got %h exp %h", wr_data, 8'(8'hA0 + n));
        end
        n++;
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL single_timeout got %0d words exp 8", n);
    end
    @(negedge clk);
    req = '0;
    #1;
    checks++;
    if (wr_count !== 4'd8) begin
      errors++;
      $display("FAIL single_count got %0d exp 8", wr_count);
    end
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      req = 4'b1111;
      for (int k = 0; k < N; k++) data[k*W +: W] = 8'(k * 16 + cyc);
      #1;
      if (cyc >= 1) begin
        e = ((cyc - 1) / MB) % N;
        checks++;
        if (gnt !== 4'(1 << e) || wr_en !== 1'b1 || owner !== 2'(e) ||
            wr_data !== 8'(e * 16 + cyc)) begin
          errors++;
          $display("FAIL rr_order cyc=%0d got gnt=%b wr=%b own=%0d d=%h exp owner %0d",
                   cyc, gnt, wr_en, owner, wr_data, e);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_full_stall();
    logic [3:0] eg [9];
    eg = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h4};
    do_reset();
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      req = 4'b0110;
      full = (cyc >= 3 && cyc <= 5);
      #1;
      checks++;
      if (gnt !== eg[cyc] || wr_en !== (|eg[cyc])) begin
        errors++;
        $display("FAIL full_stall cyc=%0d got gnt=%b wr=%b exp gnt=%b",
                 cyc, gnt, wr_en, eg[cyc]);
      end
      if (cyc >= 3 && cyc <= 5) begin
        checks++;
        if (owner !== 2'd1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL full_hold got own=%0d busy=%b exp 1 1", owner, busy);
        end
      end
    end
    full = 1'b0;
    req = '0;
  endtask

  task automatic test_req_drop();
    do_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      req = (cyc >= 3) ? 4'b1000 : 4'b1001;
      #1;
      if (cyc == 1 || cyc == 2) begin
        checks++;
        if (gnt !== 4'b0001 || wr_en !== 1'b1) begin
          errors++;
          $display("FAIL drop_own0 cyc=%0d got gnt=%b wr=%b exp 0001 1", cyc, gnt, wr_en);
        end
      end
      if (cyc == 3) begin
        checks++;
        if (wr_en !== 1'b0) begin
          errors++;
          $display("FAIL drop_nowrite got wr=%b exp 0", wr_en);
        end
      end
      if (cyc >= 4) begin
        checks++;
        if (owner !== 2'd3 || gnt !== 4'b1000 || wr_en !== 1'b1) begin
          errors++;
          $display("FAIL drop_switch cyc=%0d got own=%0d gnt=%b wr=%b exp 3 1000 1",
                   cyc, owner, gnt, wr_en);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_count_wrap();
    int n = 0;
    int cyc = 0;
    do_reset();
    while (n < 15 && cyc < 40) begin
      @(negedge clk);
      req = 4'b0001;
      #1;
      if (wr_en === 1'b1) n++;
      cyc++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (wr_count !== 4'd15) begin
      errors++;
      $display("FAIL wrap_pre got %0d exp 15", wr_count);
    end
    if (wr_en === 1'b1) n++;
    while (n < 17 && cyc < 60) begin
      @(negedge clk);
      #1;
      if (wr_en === 1'b1) n++;
      cyc++;
    end
    @(negedge clk);
    req = '0;
    #1;
    checks++;
    if (n != 17 || wr_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap_post got %0d after %0d words exp 1 after 17", wr_count, n);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    logic ew;
    do_reset();
    req = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) req[k] = ~req[k];
      end
      full = ($urandom_range(0, 3) == 0);
      data = $urandom;
      #1;
      eg = (m.busy && !full) ? 4'(1 << m.owner) : 4'b0;
      ew = m.busy && req[m.owner] && !full;
      checks++;
      if (gnt !== eg || wr_en !== ew || busy !== m.busy ||
          owner !== 2'(m.owner) || wr_count !== 4'(m.wr)) begin
        errors++;
        $display("FAIL rand cyc=%0d got gnt=%b wr=%b busy=%b own=%0d cnt=%0d exp %b %b %b %0d %0d",
                 cyc, gnt, wr_en, busy, owner, wr_count, eg, ew, m.busy, m.owner, m.wr);
      end
      if (ew) begin
        checks++;
        if (wr_data !== data[m.owner*W +: W]) begin
          errors++;
          $display("FAIL rand_data cyc=%0d got %h exp %h", cyc, wr_data, data[m.owner*W +: W]);
        end
      end
    end
    req = '0;
    full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_full_stall();
    test_req_drop();
    test_count_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
